shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width; power of two, 4..64.
REQ-002 SHALL have localparam SW = log2(WIDTH): shift-amount width and pipeline stage count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input operation present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts an operation this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 SHALL have port in_shift, input, SW bits: shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_lr, input, 1 bit: 0 = left, 1 = right.
REQ-010 SHALL have port in_mode, input, 2 bits: 00 logical, 01 rotate, 10 arithmetic, 11 reserved.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_data, output, WIDTH bits: result.

Function
REQ-014 SHALL be a log-barrel pipeline of SW registered stages; stage k conditionally shifts or rotates by 2^k using bit k of the shift amount.
REQ-015 SHALL give latency of exactly SW cycles from an accepted input to out_valid when there is no backpressure.
REQ-016 SHALL sustain one operation per cycle when out_ready stays high.
REQ-017 SHALL define transfers as: input on in_valid && in_ready at a rising edge; output on out_valid && out_ready at a rising edge.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (global advance); all stages advance together when it is high and hold when it is low.
REQ-019 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL carry a per-stage valid bit; a stage advancing with no input loads valid=0 (a bubble). Bubbles SHALL NOT be squeezed out.
REQ-021 Logical left SHALL zero-fill LSBs; logical right SHALL zero-fill MSBs.
REQ-022 Rotate SHALL wrap the bits that exit one end into the other end.
REQ-023 Arithmetic right SHALL fill with the original MSB; arithmetic left SHALL equal logical left.
REQ-024 Mode 11 SHALL behave as logical.
REQ-025 Shift amount 0 SHALL return in_data unchanged in every mode.
REQ-026 Direction and mode SHALL be captured at acceptance and travel with the operand, so operations of mixed mode can be in flight together.
REQ-027 Simultaneous output transfer and input acceptance in the same cycle SHALL lose no data.

Reset
REQ-028 While rst_n=0, all stage valid bits SHALL be 0, out_valid SHALL be 0 and out_data SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard every in-flight operation; no result for them SHALL appear after release.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.
REQ-031 The first result SHALL appear exactly SW cycles after the first accepted input after reset.

Configuration
REQ-032 Macro SHIFT_PIPE_ARITH_EN SHALL control arithmetic mode: when defined, mode 10 behaves per REQ-023.
REQ-033 When SHIFT_PIPE_ARITH_EN is undefined, mode 10 SHALL behave as logical and no sign-fill logic SHALL be synthesised.

Verification (WIDTH=16, latency 4)
REQ-034 in_data 0x4A63, shift 4, lr=0, logical -> 0xA630; same operand, rotate -> 0xA634.
REQ-035 in_data 0x4A63, shift 8, lr=1, logical -> 0x004A; same operand, rotate -> 0x634A; all four results appear in consecutive cycles with out_ready=1.
REQ-036 With SHIFT_PIPE_ARITH_EN defined: in_data 0x8000, shift 4, lr=1, mode 10 -> 0xF800. Without it: same stimulus -> 0x0800.
REQ-037 Backpressure: stream 6 operations, hold out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, out_data stable, all 6 results delivered in order with no loss or duplication.
REQ-038 Reset: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately; after release, no stale result appears and a new operation returns after 4 cycles.
REQ-039 Random stimulus across all modes and shifts 0..15 SHALL match a reference model, including shift 0 -> unchanged and shift 15 boundary cases.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined log-barrel shifter: SW = log2(WIDTH) registered stages, stage k shifts/rotates by 2^k.
// Optional arithmetic right shift (mode 10) is built only when SHIFT_PIPE_ARITH_EN is defined.
module shift_pipe #(
    parameter  int WIDTH = 16,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    in_shift,
    input  logic             in_lr,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int LAST = SW - 1;

    logic             valid_q [SW];
    logic             valid_d [SW];
    logic [WIDTH-1:0] data_q  [SW];
    logic [WIDTH-1:0] data_d  [SW];
    logic             lr_q    [SW];
    logic             lr_d    [SW];
    logic [1:0]       mode_q  [SW];
    logic [1:0]       mode_d  [SW];
    logic [SW-1:0]    shift_q [SW];
    logic [SW-1:0]    shift_d [SW];
    logic             advance_s;

    // One barrel step by a fixed distance; modes 11 (and 10 without arithmetic support) act as logical.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input int               amt,
        input logic             lr,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (mode)
            2'b01: begin
                if (lr) begin
                    r = (d >> amt) | (d << (WIDTH - amt));
                end else begin
                    r = (d << amt) | (d >> (WIDTH - amt));
                end
            end
`ifdef SHIFT_PIPE_ARITH_EN
            2'b10: begin
                // MSB is preserved by every arithmetic step, so it still equals the original sign.
                if (lr) begin
                    r = $signed(d) >>> amt;
                end else begin
                    r = d << amt;
                end
            end
`endif
            default: begin
                if (lr) begin
                    r = d >> amt;
                end else begin
                    r = d << amt;
                end
            end
        endcase
        return r;
    endfunction

    // Whole pipeline advances together whenever the output slot is free or being drained.
    always_comb begin
        advance_s = !valid_q[LAST] || out_ready;
    end

    // Next-state for every stage: stage 0 from the input port, stage k from stage k-1.
    always_comb begin
        valid_d[0] = in_valid;
        lr_d[0]    = in_lr;
        mode_d[0]  = in_mode;
        shift_d[0] = in_shift;
        if (in_shift[0]) begin
            data_d[0] = shift_step(in_data, 1, in_lr, in_mode);
        end else begin
            data_d[0] = in_data;
        end
        for (int k = 1; k < SW; k++) begin
            valid_d[k] = valid_q[k-1];
            lr_d[k]    = lr_q[k-1];
            mode_d[k]  = mode_q[k-1];
            shift_d[k] = shift_q[k-1];
            if (shift_q[k-1][k]) begin
                data_d[k] = shift_step(data_q[k-1], 1 << k, lr_q[k-1], mode_q[k-1]);
            end else begin
                data_d[k] = data_q[k-1];
            end
        end
    end

    // Stage registers: cleared asynchronously, loaded in lock-step on advance, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SW; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                lr_q[k]    <= 1'b0;
                mode_q[k]  <= 2'b00;
                shift_q[k] <= '0;
            end
        end else if (advance_s) begin
            for (int k = 0; k < SW; k++) begin
                valid_q[k] <= valid_d[k];
                data_q[k]  <= data_d[k];
                lr_q[k]    <= lr_d[k];
                mode_q[k]  <= mode_d[k];
                shift_q[k] <= shift_d[k];
            end
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed self-checking bench for shift_pipe (WIDTH=16, latency 4); honours SHIFT_PIPE_ARITH_EN.
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int SW    = 4;

`ifdef SHIFT_PIPE_ARITH_EN
    localparam logic [15:0] EXP_ASR4  = 16'hF800;
    localparam logic [15:0] EXP_ASR15 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_ASR4  = 16'h0800;
    localparam logic [15:0] EXP_ASR15 = 16'h0001;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shift;
    logic             in_lr;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int tests = 0;
    int fails = 0;

    logic [15:0] v_data [16];
    logic [3:0]  v_sh   [16];
    logic        v_lr   [16];
    logic [1:0]  v_mode [16];
    logic [15:0] v_exp  [16];

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_lr     (in_lr),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] sh,
                         input logic lr, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        in_shift = sh;
        in_lr    = lr;
        in_mode  = m;
    endtask

    task automatic set_vec(input int i, input logic [15:0] d, input logic [3:0] sh,
                           input logic lr, input logic [1:0] m, input logic [15:0] e);
        v_data[i] = d;
        v_sh[i]   = sh;
        v_lr[i]   = lr;
        v_mode[i] = m;
        v_exp[i]  = e;
    endtask

    // Streams vectors 0..n-1; after the first out_valid, out_ready is held low for stall_len cycles.
    task automatic run_stream(input int n, input int stall_len, input string tag);
        int  issue;
        int  recv;
        int  stall_left;
        bit  first_seen;
        issue      = 0;
        recv       = 0;
        stall_left = stall_len;
        first_seen = 1'b0;
        for (int cyc = 0; cyc < 300 && recv < n; cyc++) begin
            step();
            if (out_valid) first_seen = 1'b1;
            out_ready = !(first_seen && stall_left > 0);
            #1;
            if (!out_ready) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_in_ready"}, in_ready, 0);
                check({tag, "_stall_data"}, out_data, v_exp[recv]);
                stall_left--;
            end else if (out_valid) begin
                check({tag, "_data"}, out_data, v_exp[recv]);
                recv++;
            end
            if (issue < n) begin
                drive(1'b1, v_data[issue], v_sh[issue], v_lr[issue], v_mode[issue]);
                if (in_ready) issue++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, recv, n);
        step();
        check({tag, "_no_dup"}, out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0000, 4'd0, 1'b0, 2'b00);

        repeat (2) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 16'h0000);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Four back-to-back operations, exact latency of 4 and consecutive results.
        drive(1'b1, 16'h4A63, 4'd4, 1'b0, 2'b00);
        step();
        drive(1'b1, 16'h4A63, 4'd4, 1'b0, 2'b01);
        step();
        drive(1'b1, 16'h4A63, 4'd8, 1'b1, 2'b00);
        step();
        check("lat_not_early", out_valid, 0);
        drive(1'b1, 16'h4A63, 4'd8, 1'b1, 2'b01);
        step();
        in_valid = 1'b0;
        check("lsl4_valid", out_valid, 1);
        check("lsl4_data", out_data, 16'hA630);
        step();
        check("rol4_valid", out_valid, 1);
        check("rol4_data", out_data, 16'hA634);
        step();
        check("lsr8_valid", out_valid, 1);
        check("lsr8_data", out_data, 16'h004A);
        step();
        check("ror8_valid", out_valid, 1);
        check("ror8_data", out_data, 16'h634A);
        step();
        check("drain_valid", out_valid, 0);

        // Mixed modes, shift 0 and shift 15 boundaries, arithmetic and reserved mode.
        set_vec(0,  16'h8000, 4'd4,  1'b1, 2'b10, EXP_ASR4);
        set_vec(1,  16'h8001, 4'd4,  1'b0, 2'b10, 16'h0010);
        set_vec(2,  16'h8000, 4'd4,  1'b1, 2'b11, 16'h0800);
        set_vec(3,  16'h1234, 4'd0,  1'b1, 2'b01, 16'h1234);
        set_vec(4,  16'hABCD, 4'd0,  1'b0, 2'b10, 16'hABCD);
        set_vec(5,  16'h0001, 4'd15, 1'b0, 2'b00, 16'h8000);
        set_vec(6,  16'h8001, 4'd15, 1'b1, 2'b00, 16'h0001);
        set_vec(7,  16'h8001, 4'd15, 1'b0, 2'b01, 16'hC000);
        set_vec(8,  16'h8001, 4'd15, 1'b1, 2'b01, 16'h0003);
        set_vec(9,  16'h8000, 4'd15, 1'b1, 2'b10, EXP_ASR15);
        set_vec(10, 16'hF0F0, 4'd3,  1'b1, 2'b00, 16'h1E1E);
        set_vec(11, 16'h4A63, 4'd1,  1'b0, 2'b01, 16'h94C6);
        set_vec(12, 16'h7FFF, 4'd2,  1'b1, 2'b10, 16'h1FFF);
        run_stream(13, 0, "mix");

        // Six operations with a five-cycle output stall.
        set_vec(0, 16'h00F1, 4'd0, 1'b0, 2'b00, 16'h00F1);
        set_vec(1, 16'h00F1, 4'd1, 1'b0, 2'b00, 16'h01E2);
        set_vec(2, 16'h00F1, 4'd2, 1'b0, 2'b00, 16'h03C4);
        set_vec(3, 16'h00F1, 4'd3, 1'b0, 2'b00, 16'h0788);
        set_vec(4, 16'h00F1, 4'd4, 1'b0, 2'b00, 16'h0F10);
        set_vec(5, 16'h00F1, 4'd5, 1'b0, 2'b00, 16'h1E20);
        run_stream(6, 5, "bp");

        // Fill the pipe under backpressure, then reset mid-cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h4A63, 4'd0, 1'b0, 2'b00);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_in_ready", in_ready, 1);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_stale", out_valid, 0);
        end
        drive(1'b1, 16'h4A63, 4'd4, 1'b0, 2'b01);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("post_rst_not_early", out_valid, 0);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 16'hA634);
        step();
        check("post_rst_drain", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
